// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master: producer/consumer side; slave: the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              flush;
    logic              clr_err;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en, flush, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, flush, clr_err,
        output dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost thresholds,
// occupancy count, sticky overflow/underflow flags and synchronous flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise dout is
// a registered read that updates on each accepted read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    sync_fifo_param_if.slave   bus
);
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_FULL = DEPTH;
    localparam logic [ADDR_W:0]   CNT_AF   = AF_THRESH;
    localparam logic [ADDR_W:0]   CNT_AE   = AE_THRESH;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_nxt;
    logic              full_q, empty_q, af_q, ae_q;
    logic              ovf_q, udf_q;
    logic              wr_acc, rd_acc, ovf_set, udf_set;

    // Accept/reject decisions; flush swallows any request in its cycle.
    always_comb begin
        wr_acc  = bus.wr_en && (!full_q || bus.rd_en) && !bus.flush;
        rd_acc  = bus.rd_en && !empty_q && !bus.flush;
        ovf_set = bus.wr_en && full_q && !bus.rd_en && !bus.flush;
        udf_set = bus.rd_en && empty_q && !bus.flush;
        count_nxt = count_q;
        if (bus.flush)
            count_nxt = '0;
        else if (wr_acc && !rd_acc)
            count_nxt = count_q + CNT_ONE;
        else if (rd_acc && !wr_acc)
            count_nxt = count_q - CNT_ONE;
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.din;
    end

    // Pointers, occupancy and status flags, all derived from next count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_AF);
            ae_q    <= (count_nxt <= CNT_AE);
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_set)          ovf_q <= 1'b1;
            else if (bus.clr_err) ovf_q <= 1'b0;
            if (udf_set)          udf_q <= 1'b1;
            else if (bus.clr_err) udf_q <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of queue shown combinationally; zero while empty.
    assign bus.dout = empty_q ? '0 : mem[rd_ptr];
`else
    logic [DATA_W-1:0] dout_q;

    // Registered read: captures the head word on each accepted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dout_q <= '0;
        else if (bus.flush)
            dout_q <= '0;
        else if (rd_acc)
            dout_q <= mem[rd_ptr];
    end

    assign bus.dout = dout_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a queue-based reference model
// predicts every post-edge status/data snapshot; a monitor compares them.
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF_T   = DEPTH - 2;
    localparam int AE_T   = 2;

    typedef struct packed {
        logic [4:0] count;
        logic       full, empty, af, ae, ovf, udf;
        logic [7:0] dout;
    } snap_t;

    logic clk = 0;
    logic reset = 0;
    int   total = 0;
    int   bad   = 0;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf, m_udf;
    logic [7:0] m_dout;
    snap_t      exp_q[$];

    function automatic snap_t expect_now();
        snap_t e;
        e.count = 5'(mq.size());
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.af    = (mq.size() >= AF_T);
        e.ae    = (mq.size() <= AE_T);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
`ifdef FIFO_FWFT_EN
        e.dout  = (mq.size() != 0) ? mq[0] : 8'h00;
`else
        e.dout  = m_dout;
`endif
        return e;
    endfunction

    function automatic snap_t actual_now();
        snap_t a;
        a.count = bus.count;
        a.full  = bus.full;
        a.empty = bus.empty;
        a.af    = bus.almost_full;
        a.ae    = bus.almost_empty;
        a.ovf   = bus.overflow;
        a.udf   = bus.underflow;
        a.dout  = bus.dout;
        return a;
    endfunction

    task automatic model(input bit w, input logic [7:0] d, input bit r,
                         input bit f, input bit c);
        bit fl, em, ovs, uds;
        if (f) begin
            mq.delete();
            m_dout = 8'h00;
            if (c) begin m_ovf = 0; m_udf = 0; end
            return;
        end
        fl  = (mq.size() == DEPTH);
        em  = (mq.size() == 0);
        ovs = w && fl && !r;
        uds = r && em;
        if (r && !em) m_dout = mq.pop_front();
        if (w && (!fl || r)) mq.push_back(d);
        if (ovs) m_ovf = 1; else if (c) m_ovf = 0;
        if (uds) m_udf = 1; else if (c) m_udf = 0;
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit f = 0, input bit c = 0);
        @(negedge clk);
        bus.wr_en = w; bus.din = d; bus.rd_en = r;
        bus.flush = f; bus.clr_err = c;
        model(w, d, r, f, c);
        exp_q.push_back(expect_now());
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en = 0; bus.din = '0; bus.rd_en = 0;
        bus.flush = 0; bus.clr_err = 0;
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 0;
        idle_inputs();
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full",  int'(bus.full), 0);
        chk("rst_af",    int'(bus.almost_full), 0);
        chk("rst_ae",    int'(bus.almost_empty), 1);
        chk("rst_ovf",   int'(bus.overflow), 0);
        chk("rst_udf",   int'(bus.underflow), 0);
        chk("rst_dout",  int'(bus.dout), 0);
        mq.delete(); m_ovf = 0; m_udf = 0; m_dout = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    // Monitor: one expected snapshot per clock edge that had stimulus.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = actual_now();
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL snap: got cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b udf=%b dout=%h expected cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b udf=%b dout=%h",
                             a.count, a.full, a.empty, a.af, a.ae, a.ovf, a.udf, a.dout,
                             e.count, e.full, e.empty, e.af, e.ae, e.ovf, e.udf, e.dout);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        m_ovf = 0; m_udf = 0; m_dout = 8'h00;
        repeat (3) @(negedge clk);
        do_reset();

        // Reset mid-burst, then only new data comes back
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0);
        do_reset();
        step(1, 8'h77, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Fill past full, then drain past empty
        for (int i = 0; i < 16; i++) step(1, 8'(8'hFF - i), 0);
        step(1, 8'h11, 0);
        for (int i = 0; i < 17; i++) step(0, 8'h00, 1);
        step(0, 8'h00, 0, 0, 1);

        // Simultaneous write/read at full, wrap-around
        for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0);
        step(1, 8'hAA, 1);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1);

        // Simultaneous write/read at empty, then clr_err
        step(1, 8'h55, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0, 0, 1);
        // Error beats simultaneous clear
        step(0, 8'h00, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);

        // Overflow, then flush with requests present keeps error flags
        for (int i = 0; i < 17; i++) step(1, 8'(i * 3), 0);
        for (int i = 0; i < 11; i++) step(0, 8'h00, 1);
        step(1, 8'hC3, 1, 1, 0);
        step(1, 8'h3C, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1, 0, 1);

        // Randomized phases: fill-heavy, drain-heavy, balanced
        for (int i = 0; i < 900; i++) begin
            int ph, pw, pr;
            ph = (i / 60) % 3;
            pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
            step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                 $urandom_range(63) == 0, $urandom_range(15) == 0);
        end
        do_reset();
        step(1, 8'h9D, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
